// File: rtl/countdown_ctrl.sv
// Run/pause/abort controller for a down_counter: issues one-cycle enable pulses every PRESCALE
// clocks until the fed-back count reaches zero, then pulses done.
module countdown_ctrl #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned PRESCALE = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             pause_i,
    input  logic             abort_i,
    input  logic [WIDTH-1:0] count_i,
    output logic             cnt_enable_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] pulses_o
);

    typedef enum logic [1:0] {StIdle, StRun, StPaused, StDone} state_e;

    localparam logic [15:0]      PrescMax  = 16'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] PulsesMax = '1;

    state_e           state_q, state_d;
    logic [15:0]      presc_q, presc_d;
    logic             en_q, en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] pulses_q, pulses_d;
    logic             count_zero;

    assign count_zero = (count_i == '0);

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        en_d     = 1'b0;
        done_d   = 1'b0;
        pulses_d = pulses_q;

        if (abort_i) begin
            state_d = StIdle;
            presc_d = '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_i) begin
                        presc_d  = '0;
                        pulses_d = '0;
                        if (count_zero) begin
                            state_d = StDone;
                            done_d  = 1'b1;
                        end else begin
                            state_d = StRun;
                        end
                    end
                end
                StRun, StPaused: begin
                    if (pause_i) begin
                        state_d = StPaused;
                    end else begin
                        state_d = StRun;
                        // count is stale while an enable is in flight, so never finish then
                        if (count_zero && !en_q) begin
                            state_d = StDone;
                            done_d  = 1'b1;
                        end else if (presc_q == PrescMax) begin
                            presc_d = '0;
                            if (!count_zero) begin
                                en_d = 1'b1;
                                if (pulses_q != PulsesMax) begin
                                    pulses_d = pulses_q + WIDTH'(1);
                                end
                            end
                        end else begin
                            presc_d = presc_q + 16'd1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        busy_d = (state_d == StRun) || (state_d == StPaused);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            presc_q  <= '0;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pulses_q <= '0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            en_q     <= en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pulses_q <= pulses_d;
        end
    end

    assign cnt_enable_o = en_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign pulses_o     = pulses_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl with a behavioural 4-bit down_counter closing the loop.
module tb_countdown_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, pause, abort;
    logic [3:0] cnt;
    logic       cnt_en, busy, done;
    logic [3:0] pulses;
    logic       load;
    logic [3:0] load_val;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    countdown_ctrl #(
        .WIDTH    (4),
        .PRESCALE (4)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .pause_i      (pause),
        .abort_i      (abort),
        .count_i      (cnt),
        .cnt_enable_o (cnt_en),
        .busy_o       (busy),
        .done_o       (done),
        .pulses_o     (pulses)
    );

    // down_counter stand-in: decrements on the edge that ends an enable pulse
    always @(posedge clk) begin
        if (load) cnt <= load_val;
        else if (cnt_en && cnt != 4'd0) cnt <= cnt - 4'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load_count(input logic [3:0] v);
        load_val = v;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();   // E0
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;
        load = 1'b0; load_val = 4'd0;

        // reset and idle
        tick(); tick();
        chk("rst_en", 32'(cnt_en), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_en", 32'(cnt_en), 0);
            chk("idle_busy", 32'(busy), 0);
            chk("idle_done", 32'(done), 0);
            chk("idle_pulses", 32'(pulses), 0);
        end

        // normal run, count=3
        load_count(4'd3);
        do_start();
        chk("run_busy0", 32'(busy), 1);
        chk("run_en0", 32'(cnt_en), 0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("run_en", 32'(cnt_en), 32'(k == 4 || k == 8 || k == 12));
            chk("run_done", 32'(done), 32'(k == 14));
            chk("run_busy", 32'(busy), 32'(k < 14));
            chk("run_cnt", 32'(cnt), (k >= 13) ? 0 : (k >= 9) ? 1 : (k >= 5) ? 2 : 3);
        end
        chk("run_pulses", 32'(pulses), 3);

        // zero start
        load_count(4'd0);
        do_start();
        chk("zero_done", 32'(done), 1);
        chk("zero_en", 32'(cnt_en), 0);
        chk("zero_pulses", 32'(pulses), 0);
        chk("zero_busy", 32'(busy), 0);
        tick();
        chk("zero_done1", 32'(done), 0);
        chk("zero_en1", 32'(cnt_en), 0);

        // pause for 5 cycles starting 2 cycles after E0, count=2
        load_count(4'd2);
        do_start();
        for (int k = 1; k <= 17; k++) begin
            pause = (k >= 3 && k <= 7);
            tick();
            chk("pause_en", 32'(cnt_en), 32'(k == 9 || k == 13));
            chk("pause_done", 32'(done), 32'(k == 15));
            chk("pause_busy", 32'(busy), 32'(k < 15));
        end
        pause = 1'b0;
        chk("pause_pulses", 32'(pulses), 2);
        chk("pause_cnt", 32'(cnt), 0);

        // abort mid-run, count=5, abort sampled at E6
        load_count(4'd5);
        do_start();
        for (int k = 1; k <= 6; k++) begin
            abort = (k == 6);
            tick();
            chk("abort_en", 32'(cnt_en), 32'(k == 4));
        end
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("abort_en_after", 32'(cnt_en), 0);
            chk("abort_done_after", 32'(done), 0);
        end
        chk("abort_cnt", 32'(cnt), 4);
        chk("abort_pulses", 32'(pulses), 1);

        // asynchronous reset while cnt_enable is high
        load_count(4'd3);
        do_start();
        for (int k = 1; k <= 4; k++) tick();
        chk("arst_pre_en", 32'(cnt_en), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_en", 32'(cnt_en), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_pulses", 32'(pulses), 0);
        tick();
        rst_n = 1'b1;
        chk("arst_cnt_held", 32'(cnt), 3);
        do_start();
        chk("rearm_busy0", 32'(busy), 1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("rearm_en", 32'(cnt_en), 32'(k == 4));
        end
        chk("rearm_pulses", 32'(pulses), 1);
        chk("rearm_cnt", 32'(cnt), 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/countdown_ctrl.md
# countdown_ctrl

Run/pause/abort controller that sits directly upstream of the 4-bit `down_counter`. It generates its `enable` input as single-cycle pulses, one every PRESCALE clocks. It reads the counter's `count` output back and stops issuing pulses when the count reaches zero. It then reports completion with a one-cycle `done` pulse and tracks how many decrement pulses it has issued.

## Interface
- `WIDTH`, 4: width of the counter value being controlled and of `pulses`.
- `PRESCALE`, 4: clocks between successive enable pulses; legal range 2..65535.
- `clk`  in  1  rising-edge clock shared with `down_counter`.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `start`  in  1  level; sampled in IDLE or DONE; begins a run.
- `pause`  in  1  level; while 1 in RUN/PAUSED, the run is frozen.
- `abort`  in  1  level; returns to IDLE from any state.
- `count`  in  WIDTH  current value from `down_counter`.
- `cnt_enable`  out  1  registered; drives `down_counter.enable`; one-cycle pulses.
- `busy`  out  1  registered; 1 in RUN or PAUSED.
- `done`  out  1  registered; one-cycle pulse on entry to DONE.
- `pulses`  out  WIDTH  registered; number of enable pulses issued in the current run.

## Operation
- States: IDLE, RUN, PAUSED, DONE. Encoding is free.
- Reset (`reset`=0, asynchronous) forces the following: state IDLE, prescaler 0, `cnt_enable`=0, `busy`=0, `done`=0, `pulses`=0.
- Input priority each edge is abort > pause > start.
- IDLE/DONE with `start`=1 and `abort`=0:
  - Prescaler and `pulses` clear to 0.
  - If `count`≠0, go to RUN.
  - If `count`=0, go directly to DONE and pulse `done`.
- RUN:
  - The prescaler increments every cycle.
  - When it equals PRESCALE-1, it wraps to 0. If `count`≠0 at that edge, `cnt_enable` is set for exactly one cycle and `pulses` increments, saturating at 2^WIDTH-1.
  - If `count`=0 and `cnt_enable`=0 at an edge, go to DONE and pulse `done`; no further enable is issued.
- RUN with `pause`=1 → PAUSED. PAUSED with `pause`=0 → RUN. The prescaler value is held across the pause. A pending `cnt_enable` pulse still completes; it is never stretched or dropped.
- `abort`=1 in any state → IDLE. Prescaler clears and `cnt_enable` clears at that edge. `pulses` holds its value for inspection.
- DONE holds, with `busy`=0, until `start` or `abort`.
- `start` held high across DONE immediately re-arms at the next edge. This is intended (auto-repeat).
- `count` is treated as a value that changes only on the edge after a `cnt_enable` pulse. The controller never decides completion in the same cycle that `cnt_enable` is high. PRESCALE≥2 guarantees the new count is visible before the next pulse.

## Timing
- Let E0 be the edge that samples `start`. `busy` is 1 from E0.
- First `cnt_enable` is high for the cycle after edge E(PRESCALE). The n-th pulse is high after edge E(n·PRESCALE).
- `down_counter` decrements on the edge ending each pulse. With initial count N, the last pulse ends at E(N·PRESCALE+1).
- `done` is high for the single cycle after edge E(N·PRESCALE+2). `busy` falls at the same edge.
- Pause of P cycles delays all subsequent events by exactly P cycles.
- Abort takes effect at the next edge. `cnt_enable`, `busy` and `done` are all 0 in the following cycle.
- Reset mid-run clears all outputs immediately (asynchronous); the first valid start is sampled at the first rising edge after release.

## Test plan
- Reset and idle: hold `reset`=0 for 2 cycles, then release with no start. Required: `cnt_enable`=0, `busy`=0, `done`=0, `pulses`=0 for 20 cycles.
- Normal run: PRESCALE=4, count=3, `start` pulse at E0. Required:
  - `cnt_enable` high in the cycles after E4, E8 and E12 only.
  - `count` goes 3→2→1→0.
  - `done` high in the cycle after E14; `pulses`=3.
- Zero start: count=0, `start` at E0. Required: DONE entered at E0 with `done` high for one cycle, no `cnt_enable`, `pulses`=0.
- Pause: PRESCALE=4, count=2, `pause`=1 for 5 cycles starting 2 cycles after E0. Required: pulses after E9 and E13, `done` after E15, `busy`=1 throughout the pause.
- Abort mid-run: count=5, `abort` 1 cycle at E6. Required:
  - IDLE at E6 with `busy`=0.
  - No further `cnt_enable`; `count` holds 4; `pulses` holds 1; no `done`.
- Asynchronous reset mid-pulse: assert `reset`=0 while `cnt_enable`=1, between edges. Required: `cnt_enable` drops without waiting for a clock edge; state IDLE; a subsequent `start` restarts the timing from E0.
